tff_toggle_decoder: RTL
=======================

# tff_toggle_decoder

Receive-side counterpart of the toggle flip-flop line driver. A T flip-flop toggles its output once for every symbol whose T input is 1, so the `q` line carries a toggle-encoded stream. This block samples such a line, locks to symbol timing, and recovers the original T symbol stream. It also keeps a toggle count and flags an idle line. It sits directly on the line driven by a `tff` instance, in the same clock domain or, with synchronisation enabled, across domains.

## Interface
- `DIV`, 4: clocks per symbol; legal values are 2 or more.
- `CNT_W`, 8: width of the toggle counter.
- `IDLE_RUN`, 8: number of consecutive non-toggle symbols that declares the line idle; legal values are 1 or more.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  decoder enable.
- `q_in`  in  1  toggle-encoded line (a `tff` `q` output).
- `clr_cnt`  in  1  synchronous clear of `toggle_cnt`.
- `t_out`  out  1  recovered T symbol; meaningful only while `t_valid` is high.
- `t_valid`  out  1  one-cycle strobe per recovered symbol.
- `toggle_cnt`  out  CNT_W  count of recovered symbols with value 1; saturates at its maximum.
- `idle`  out  1  high while the decoder is in IDLE.

## Operation
**Line sampling.**
- `q_s` is the registered copy of `q_in`.
- `q_p` is `q_s` delayed by one clock.
- `edge` = `q_s` XOR `q_p`.

**State machine.** States are IDLE and LOCK.
- IDLE to LOCK: on `edge` while `en` is 1. On this transition, `phase` loads 0 and `last` keeps the pre-edge level.
- LOCK to IDLE: when the run of consecutive 0 symbols reaches `IDLE_RUN`, or when `en` is 0.

**Phase counter** (0 to DIV-1, LOCK only).
- Increments every clock and wraps from DIV-1 to 0.
- `edge` forces `phase` to 0 (resynchronisation). This has priority over both increment and wrap.

**Symbol recovery** (LOCK only). When `phase` == DIV/2 (integer division):
- `t_out` <= `q_s` XOR `last`.
- `last` <= `q_s`.
- `t_valid` <= 1.
- At all other times `t_valid` <= 0, and `t_out` holds its value.

**Run counter.**
- Increments on each recovered 0 and clears on each recovered 1.
- Clears on entry to IDLE.
- When it reaches `IDLE_RUN`, the state becomes IDLE on the same clock edge that registers that strobe.

**Toggle counter.**
- Increments on each recovered 1 and saturates at 2^CNT_W-1.
- `clr_cnt` has priority over the increment: if both occur in the same cycle, the result is 0.
- Unaffected by `en` and by state changes.

**Enable.** `en` = 0 forces IDLE, `phase` = 0, run count = 0 and `t_valid` = 0. The sampling flops keep running.

**Reset values.** `t_out` 0, `t_valid` 0, `toggle_cnt` 0, `idle` 1, state IDLE, `q_s`/`q_p`/`last` 0, `phase` 0, run count 0.

**Reset mid-operation.** Asserting `rst` in LOCK immediately returns every register to its reset value. No partial strobe is emitted.

## Timing
- All outputs are registered.
- Let E0 be the first rising edge at which a `q_in` transition is captured into `q_s`. `phase` becomes 0 at E1 and `t_valid` rises at edge E(1+DIV/2), lasting exactly one cycle. For DIV=4 this is E3.
- With the configuration macro defined, every latency above grows by one clock.
- In steady LOCK, the `t_valid` pulses are exactly DIV clocks apart when no edges occur.
- An edge landing on `phase` == DIV/2 loads `phase` 0 and suppresses that cycle's strobe. Sampling restarts from the new edge.
- `idle` rises on the clock edge that registers the `IDLE_RUN`-th consecutive 0 strobe.

## Configuration
- Macro: `TFF_DEC_SYNC_EN`.
- **Defined:** `q_in` passes through a two-flop synchroniser before `q_s`, making `q_in` safe to be asynchronous to `clk`. All synchroniser flops reset to 0.
- **Undefined:** `q_s` is a single register, and `q_in` must be synchronous to `clk`.

## Structure
- **Package `tff_pkg`:**
  - state enum `tff_dec_state_t` {IDLE, LOCK};
  - default constants `TFF_DEC_DIV` = 4, `TFF_DEC_CNT_W` = 8, `TFF_DEC_IDLE_RUN` = 8.
- **Sub-module `tff_line_sync`:** contains the optional synchroniser, `q_s`, `q_p` and `edge` generation, with ports `clk`, `rst`, `d`, `q`, `edge`.
- **Top level:** contains the FSM, phase counter, run counter and toggle counter.

## Test plan
- **Reset:** hold `rst`=0 for 3 clocks with `q_in` toggling → `idle`=1, `t_valid`=0, `toggle_cnt`=0 throughout.
- **Basic decode:** DIV=4; drive `q_in` from a `tff` fed T = 1,0,1,1,0 at 4 clocks per symbol → `t_out` strobes 1,0,1,1,0, with the first strobe at E3 after capture; `toggle_cnt`=3.
- **Idle timeout:** IDLE_RUN=8; after the last toggle, hold `q_in` constant → exactly 8 zero strobes, then `idle`=1 on the 8th strobe edge; no further strobes.
- **Saturation and clear:**
  - CNT_W=2; send 5 one-symbols → `toggle_cnt` stops at 3.
  - Pulse `clr_cnt` in the same cycle as a recovered 1 → `toggle_cnt`=0.
- **Mid-operation abort:**
  - Assert `rst` while `phase`=1 in LOCK → all outputs return to reset values immediately, with no strobe.
  - Separately, drop `en` for 1 clock → IDLE; the next toggle relocks with the first strobe = 1.
- **Resync:** shift one `q_in` edge one clock late → `phase` realigns to 0 at the late edge, and the recovered symbols are unchanged.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared types and default configuration for the toggle-stream decoder.
package tff_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } tff_dec_state_t;

  localparam int unsigned TFF_DEC_DIV      = 4;
  localparam int unsigned TFF_DEC_CNT_W    = 8;
  localparam int unsigned TFF_DEC_IDLE_RUN = 8;

endpackage

// File: rtl/tff_toggle_decoder_if.sv
// Line/control/status bundle between a host and the toggle-stream decoder.
interface tff_toggle_decoder_if import tff_pkg::*; #(
  parameter int unsigned CNT_W = TFF_DEC_CNT_W
) ();

  logic             en;
  logic             q_in;
  logic             clr_cnt;
  logic             t_out;
  logic             t_valid;
  logic [CNT_W-1:0] toggle_cnt;
  logic             idle;

  modport master (
    output en, q_in, clr_cnt,
    input  t_out, t_valid, toggle_cnt, idle
  );

  modport slave (
    input  en, q_in, clr_cnt,
    output t_out, t_valid, toggle_cnt, idle
  );

endinterface

// File: rtl/tff_line_sync.sv
// Line sampler: optional synchroniser, registered line level q_s, delayed copy q_p
// and the transition flag. Build option: TFF_DEC_SYNC_EN adds one metastability
// flop ahead of q_s, so q_s becomes the second synchroniser stage.
module tff_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic line_edge
);

  logic q_s_d, q_s_q, q_p_q;

`ifdef TFF_DEC_SYNC_EN
  logic meta_q;

  // First synchroniser stage; may go metastable when d is asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) meta_q <= 1'b0;
    else      meta_q <= d;
  end

  assign q_s_d = meta_q;
`else
  assign q_s_d = d;
`endif

  // Line level and its one-clock-delayed copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_s_q <= 1'b0;
      q_p_q <= 1'b0;
    end else begin
      q_s_q <= q_s_d;
      q_p_q <= q_s_q;
    end
  end

  assign q         = q_s_q;
  assign line_edge = q_s_q ^ q_p_q;

endmodule

// File: rtl/tff_toggle_decoder.sv
// Recovers the T symbol stream from a toggle-encoded line: locks phase to line
// transitions, samples mid-symbol, counts recovered ones and times out to IDLE
// after a run of zero symbols. Build option: TFF_DEC_SYNC_EN (see tff_line_sync).
module tff_toggle_decoder import tff_pkg::*; #(
  parameter int unsigned DIV      = TFF_DEC_DIV,
  parameter int unsigned CNT_W    = TFF_DEC_CNT_W,
  parameter int unsigned IDLE_RUN = TFF_DEC_IDLE_RUN
) (
  input logic                clk,
  input logic                rst,
  tff_toggle_decoder_if.slave bus
);

  localparam int unsigned PhW  = $clog2(DIV);
  localparam int unsigned RunW = $clog2(IDLE_RUN + 1);

  localparam logic [PhW-1:0]   PhaseLast = PhW'(DIV - 1);
  localparam logic [PhW-1:0]   PhaseMid  = PhW'(DIV / 2);
  localparam logic [RunW-1:0]  RunMax    = RunW'(IDLE_RUN);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic q_s, line_edge;

  tff_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .d         (bus.q_in),
    .q         (q_s),
    .line_edge (line_edge)
  );

  tff_dec_state_t   state_d, state_q;
  logic [PhW-1:0]   phase_d, phase_q;
  logic [RunW-1:0]  run_d, run_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             last_d, last_q;
  logic             t_out_d, t_out_q;
  logic             t_valid_d, t_valid_q;
  logic             idle_d, idle_q;
  logic             strobe, sym;

  // Next-state: lock/timeout FSM, phase tracking, symbol recovery and counters.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    run_d     = run_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    t_out_d   = t_out_q;
    t_valid_d = 1'b0;
    strobe    = 1'b0;
    sym       = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      phase_d = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_edge) begin
            state_d = LOCK;
            phase_d = '0;
            run_d   = '0;
            // q_s already holds the post-edge level; reference the level before it.
            last_d  = ~q_s;
          end
        end
        LOCK: begin
          // A transition realigns the symbol grid, overriding increment and wrap.
          if (line_edge)                phase_d = '0;
          else if (phase_q == PhaseLast) phase_d = '0;
          else                          phase_d = phase_q + PhW'(1);

          // Strobe is registered alongside phase reaching mid-symbol.
          if (phase_d == PhaseMid) begin
            strobe    = 1'b1;
            sym       = q_s ^ last_q;
            t_out_d   = sym;
            last_d    = q_s;
            t_valid_d = 1'b1;
            if (sym) begin
              run_d = '0;
            end else begin
              run_d = run_q + RunW'(1);
              if (run_d == RunMax) begin
                state_d = IDLE;
                run_d   = '0;
                phase_d = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bus.clr_cnt)                           cnt_d = '0;
    else if (strobe && sym && cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);

    idle_d = (state_d == IDLE);
  end

  // Single state register for FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      run_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      t_out_q   <= 1'b0;
      t_valid_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      run_q     <= run_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      t_out_q   <= t_out_d;
      t_valid_q <= t_valid_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.t_out      = t_out_q;
  assign bus.t_valid    = t_valid_q;
  assign bus.toggle_cnt = cnt_q;
  assign bus.idle       = idle_q;

endmodule
